// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU core: FSM state encoding and
// instruction-word field positions.
package hack_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_e;

  localparam int IS_C   = 15;
  localparam int A_BIT  = 12;
  localparam int CMP_HI = 11;
  localparam int CMP_LO = 6;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;
  localparam int J_LT   = 2;
  localparam int J_EQ   = 1;
  localparam int J_GT   = 0;

endpackage

// File: rtl/hack_cpu_alu.sv
// Hack ALU: six-bit controlled 16-bit ALU with zero and negative flags.
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x_z, x_n, y_z, y_n, f_out;

  always_comb begin
    x_z   = zx ? 16'h0000 : x;
    x_n   = nx ? ~x_z : x_z;
    y_z   = zy ? 16'h0000 : y;
    y_n   = ny ? ~y_z : y_z;
    f_out = f ? (x_n + y_n) : (x_n & y_n);
    out   = no ? ~f_out : f_out;
    zr    = (out == 16'h0000);
    ng    = out[15];
  end

endmodule

// File: rtl/hack_cpu.sv
// Multi-cycle Hack CPU: FETCH/DECODE/EXEC per instruction against
// single-cycle-latency synchronous ROM and RAM.
module hack_cpu
  import hack_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [14:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [14:0] ram_addr,
  input  logic [15:0] ram_rdata,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  output logic [14:0] pc,
  output logic        retire
);

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [14:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;

  logic [15:0] alu_y, alu_out;
  logic [5:0]  cmp;
  logic        zr, ng, take;
  logic [14:0] pc_inc;

  assign cmp    = ir_q[CMP_HI:CMP_LO];
  assign alu_y  = ir_q[A_BIT] ? ram_rdata : a_q;
  assign pc_inc = pc_q + 15'd1;
  assign take   = (ir_q[J_LT] & ng) | (ir_q[J_EQ] & zr) | (ir_q[J_GT] & ~ng & ~zr);

  alu u_alu (
    .x  (d_q),
    .y  (alu_y),
    .zx (cmp[5]),
    .nx (cmp[4]),
    .zy (cmp[3]),
    .ny (cmp[2]),
    .f  (cmp[1]),
    .no (cmp[0]),
    .out(alu_out),
    .zr (zr),
    .ng (ng)
  );

  assign rom_addr  = pc_q;
  assign pc        = pc_q;
  assign ram_addr  = a_q[14:0];
  assign ram_wdata = alu_out;

  // Jump target and M address both use A as it was before this EXEC.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ram_we  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        ir_d    = rom_data;
        state_d = EXEC;
      end
      EXEC: begin
        retire  = 1'b1;
        state_d = FETCH;
        if (!ir_q[IS_C]) begin
          a_d  = {1'b0, ir_q[14:0]};
          pc_d = pc_inc;
        end else begin
          ram_we = ir_q[DEST_M];
          if (ir_q[DEST_A]) a_d = alu_out;
          if (ir_q[DEST_D]) d_d = alu_out;
          pc_d = take ? a_q[14:0] : pc_inc;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      a_q     <= 16'h0000;
      d_q     <= 16'h0000;
      pc_q    <= 15'h0000;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_hack_cpu.sv
// Scoreboard bench for hack_cpu: an ISA-level reference model queues one
// expectation per instruction; a monitor pops and checks at each retire.
module tb_hack_cpu;
  import hack_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] rom_addr, ram_addr, pc;
  logic [15:0] rom_data, ram_rdata, ram_wdata;
  logic        ram_we, retire;

  hack_cpu dut (
    .clk      (clk),
    .reset    (reset),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .ram_addr (ram_addr),
    .ram_rdata(ram_rdata),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we),
    .pc       (pc),
    .retire   (retire)
  );

  always #5 clk = ~clk;

  logic [15:0] rom   [0:32767];
  logic [15:0] ram   [0:32767];
  logic [15:0] m_ram [0:32767];

  always @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    ram_rdata <= ram[ram_addr];
    if (ram_we) ram[ram_addr] <= ram_wdata;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [14:0] pc;
    logic [14:0] npc;
    logic [14:0] addr;
    logic        isc;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] a;
    logic [15:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   pend = 0;
  int   cyc = 0;

  // Hack comp table, written from the ISA rather than the bitwise ALU.
  function automatic logic [15:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] c);
    case (c)
      6'b101010: return 16'h0000;
      6'b111111: return 16'h0001;
      6'b111010: return 16'hFFFF;
      6'b001100: return x;
      6'b110000: return y;
      6'b001101: return ~x;
      6'b110001: return ~y;
      6'b001111: return -x;
      6'b110011: return -y;
      6'b011111: return x + 16'd1;
      6'b110111: return y + 16'd1;
      6'b001110: return x - 16'd1;
      6'b110010: return y - 16'd1;
      6'b000010: return x + y;
      6'b010011: return x - y;
      6'b000111: return y - x;
      6'b000000: return x & y;
      6'b010101: return x | y;
      default:   return 16'h0000;
    endcase
  endfunction

  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;

  task automatic model_run(input int n);
    exp_t e;
    logic [15:0] ins, y, o;
    logic [14:0] npc;
    logic zr, ng, jmp;
    for (int i = 0; i < n; i++) begin
      ins     = rom[m_pc];
      e.pc    = m_pc;
      e.addr  = m_a[14:0];
      e.isc   = ins[15];
      e.we    = 1'b0;
      e.wdata = 16'h0000;
      if (!ins[15]) begin
        m_a  = {1'b0, ins[14:0]};
        m_pc = m_pc + 15'd1;
      end else begin
        y   = ins[12] ? m_ram[m_a[14:0]] : m_a;
        o   = ref_alu(m_d, y, ins[11:6]);
        zr  = (o == 16'h0000);
        ng  = o[15];
        jmp = (ins[2] && ng) || (ins[1] && zr) || (ins[0] && !ng && !zr);
        e.we    = ins[3];
        e.wdata = o;
        if (ins[3]) m_ram[m_a[14:0]] = o;
        npc = jmp ? m_a[14:0] : (m_pc + 15'd1);
        if (ins[5]) m_a = o;
        if (ins[4]) m_d = o;
        m_pc = npc;
      end
      e.npc = m_pc;
      e.a   = m_a;
      e.d   = m_d;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      cyc  = 0;
      pend = 0;
    end else begin
      if (pend) begin
        chk("pc_after", 32'(pc), 32'(cur.npc));
        chk("A_after", 32'(dut.a_q), 32'(cur.a));
        chk("D_after", 32'(dut.d_q), 32'(cur.d));
        pend = 0;
      end
      chk("retire_cadence", 32'(retire), 32'((cyc % 3) == 2));
      if (retire) begin
        if (sb.size() == 0) begin
          chk("extra_retire", 32'(retire), 32'(0));
        end else begin
          cur = sb.pop_front();
          chk("pc_exec", 32'(pc), 32'(cur.pc));
          chk("ram_addr_exec", 32'(ram_addr), 32'(cur.addr));
          chk("ram_we_exec", 32'(ram_we), 32'(cur.we));
          if (cur.isc) chk("ram_wdata_exec", 32'(ram_wdata), 32'(cur.wdata));
          pend = 1;
        end
      end else begin
        chk("ram_we_idle", 32'(ram_we), 32'(0));
      end
      cyc++;
    end
  end

  logic [15:0] progs [8][6];
  int          nins  [8];

  task automatic load(input int t);
    for (int i = 0; i < 32768; i++) begin
      rom[i]   = 16'h0000;
      ram[i]   = 16'h0000;
      m_ram[i] = 16'h0000;
    end
    for (int i = 0; i < 6; i++) rom[i] = progs[t][i];
    rom[32767] = 16'h0003;
    ram[7]     = 16'h1234;
    m_ram[7]   = 16'h1234;
    m_a  = 16'h0000;
    m_d  = 16'h0000;
    m_pc = 15'h0000;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic enter_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int bad;
    int nret;
    progs[0] = '{16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    progs[1] = '{16'h0005, 16'hEC10, 16'hE308, 16'h0000, 16'h0000, 16'h0000};
    progs[2] = '{16'h0005, 16'hEC10, 16'h0010, 16'hE301, 16'h0000, 16'h0000};
    progs[3] = '{16'h0000, 16'hEC10, 16'h0010, 16'hE301, 16'h0000, 16'h0000};
    progs[4] = '{16'hEE90, 16'h0010, 16'hE301, 16'h0000, 16'h0000, 16'h0000};
    progs[5] = '{16'h0010, 16'hEA87, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    progs[6] = '{16'h0007, 16'hFC10, 16'hE308, 16'h0000, 16'h0000, 16'h0000};
    progs[7] = '{16'h0003, 16'hEC10, 16'h0020, 16'hE32F, 16'h0000, 16'h0000};
    nins = '{1, 3, 4, 4, 3, 2, 3, 4};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'(0));
    chk("rst_rom_addr", 32'(rom_addr), 32'(0));
    chk("rst_ram_addr", 32'(ram_addr), 32'(0));
    chk("rst_ram_we", 32'(ram_we), 32'(0));
    chk("rst_retire", 32'(retire), 32'(0));
    chk("rst_state", 32'(dut.state_q), 32'(FETCH));

    for (int t = 0; t < 9; t++) begin
      if (t < 8) begin
        load(t);
        model_run(nins[t]);
      end else begin
        // pc wrap: jump to 0x7FFF, run the A-instruction there, land on 0
        load(0);
        rom[0] = 16'h7FFF;
        rom[1] = 16'hEA87;
        model_run(4);
      end
      release_reset();
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        #1;
        if (sb.size() == 0 && !pend) break;
      end
      chk($sformatf("drain_t%0d", t), 32'(sb.size()) + 32'(pend), 32'(0));
      sb.delete();
      enter_reset();
      bad = 0;
      for (int i = 0; i < 64; i++) if (ram[i] !== m_ram[i]) bad++;
      chk($sformatf("ram_contents_t%0d", t), 32'(bad), 32'(0));
    end

    // Reset asserted during the EXEC of M=D must kill the write at once.
    load(1);
    model_run(3);
    release_reset();
    nret = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (retire) nret++;
      if (nret == 3) break;
    end
    chk("mid_we_before", 32'(ram_we), 32'(1));
    reset = 1'b1;
    #1;
    chk("mid_we_drop", 32'(ram_we), 32'(0));
    chk("mid_retire_drop", 32'(retire), 32'(0));
    chk("mid_pc", 32'(pc), 32'(0));
    chk("mid_A", 32'(dut.a_q), 32'(0));
    chk("mid_D", 32'(dut.d_q), 32'(0));
    chk("mid_state", 32'(dut.state_q), 32'(FETCH));
    @(posedge clk);
    #1;
    chk("mid_no_write", 32'(ram[5]), 32'(0));
    sb.delete();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
